// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction/memory handshake and datapath-control bundle
interface multicycle_controller_if #(
    parameter int CNT_W = 16
) ();
    logic [10:0]      Instruction;
    logic             mem_ready;
    logic             Zero;
    logic             Reg2Loc;
    logic             ALUSrc;
    logic             MemtoReg;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             Branch;
    logic             UncondBranch;
    logic             IRWrite;
    logic             PCWrite;
    logic [1:0]       ALUOp;
    logic             fault;
    logic [CNT_W-1:0] retired;

    // Controller side: consumes opcode/handshake/flag, drives the datapath controls.
    modport master (
        input  Instruction, mem_ready, Zero,
        output Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
        output Branch, UncondBranch, IRWrite, PCWrite, ALUOp, fault, retired
    );

    // Datapath/memory side: the mirror image of the controller.
    modport slave (
        output Instruction, mem_ready, Zero,
        input  Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
        input  Branch, UncondBranch, IRWrite, PCWrite, ALUOp, fault, retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle LEGv8-subset control FSM with memory timeout fault
module multicycle_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);

    localparam int WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_ILL,
        C_R,
        C_LDUR,
        C_STUR,
        C_CBZ,
        C_CBNZ,
        C_B
    } cls_t;

    state_t              r_state;
    state_t              w_next;
    logic [10:0]         r_ir;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_retired;
    cls_t                w_cls;

    logic                w_load_ir;
    logic                w_wait_inc;
    logic                w_retire;

    logic                w_reg2loc;
    logic                w_alusrc;
    logic                w_memtoreg;
    logic                w_regwrite;
    logic                w_memread;
    logic                w_memwrite;
    logic                w_branch;
    logic                w_uncond;
    logic                w_irwrite;
    logic                w_pcwrite;
    logic [1:0]          w_aluop;
    logic                w_fault;

    // Opcode class of the latched instruction; anything unmatched is illegal.
    always_comb begin
        w_cls = C_ILL;
        casez (r_ir)
            11'b11111000010: w_cls = C_LDUR;
            11'b11111000000: w_cls = C_STUR;
            11'b10110100???: w_cls = C_CBZ;
            11'b10110101???: w_cls = C_CBNZ;
            11'b000101?????: w_cls = C_B;
            11'b1??0101?000: w_cls = C_R;
            default:         w_cls = C_ILL;
        endcase
    end

    // Next-state and control decode for every state.
    always_comb begin
        w_next     = r_state;
        w_load_ir  = 1'b0;
        w_wait_inc = 1'b0;
        w_retire   = 1'b0;
        w_reg2loc  = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_branch   = 1'b0;
        w_uncond   = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_aluop    = 2'b00;
        w_fault    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                if (bus.mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_load_ir = 1'b1;
                    w_next    = S_DECODE;
                end else if (r_wait == WAIT_LAST) begin
                    w_next = S_FAULT;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            S_DECODE: begin
                w_reg2loc = (w_cls == C_STUR) || (w_cls == C_CBZ) || (w_cls == C_CBNZ);
                w_next    = (w_cls == C_ILL) ? S_FAULT : S_EXEC;
            end

            S_EXEC: begin
                case (w_cls)
                    C_R: begin
                        w_aluop = 2'b10;
                        w_next  = S_WB;
                    end
                    C_LDUR, C_STUR: begin
                        w_alusrc = 1'b1;
                        w_next   = S_MEM;
                    end
                    C_CBZ, C_CBNZ: begin
                        w_aluop   = 2'b01;
                        w_reg2loc = 1'b1;
                        // Branch is taken on Zero for CBZ and on !Zero for CBNZ.
                        if (bus.Zero == (w_cls == C_CBZ)) begin
                            w_branch  = 1'b1;
                            w_pcwrite = 1'b1;
                        end
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    C_B: begin
                        w_uncond  = 1'b1;
                        w_pcwrite = 1'b1;
                        w_next    = S_FETCH;
                        w_retire  = 1'b1;
                    end
                    default: w_next = S_FAULT;
                endcase
            end

            S_MEM: begin
                w_alusrc   = 1'b1;
                w_memread  = (w_cls == C_LDUR);
                w_memwrite = (w_cls == C_STUR);
                w_reg2loc  = (w_cls == C_STUR);
                if (bus.mem_ready) begin
                    if (w_cls == C_LDUR) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_next = S_FAULT;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            S_WB: begin
                w_regwrite = 1'b1;
                w_memtoreg = (w_cls == C_LDUR);
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end

            S_FAULT: begin
                w_fault = 1'b1;
            end

            default: begin
                w_next = S_FAULT;
            end
        endcase
    end

    // State register; reset forces FETCH without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction register, memory wait counter and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir      <= '0;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            if (w_load_ir) begin
                r_ir <= bus.Instruction;
            end
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // IR/PC strobes follow mem_ready in FETCH, so they are masked while reset holds the FSM.
    assign bus.Reg2Loc      = w_reg2loc;
    assign bus.ALUSrc       = w_alusrc;
    assign bus.MemtoReg     = w_memtoreg;
    assign bus.RegWrite     = w_regwrite;
    assign bus.MemRead      = w_memread;
    assign bus.MemWrite     = w_memwrite;
    assign bus.Branch       = w_branch;
    assign bus.UncondBranch = w_uncond;
    assign bus.IRWrite      = w_irwrite & ~rst;
    assign bus.PCWrite      = w_pcwrite & ~rst;
    assign bus.ALUOp        = w_aluop;
    assign bus.fault        = w_fault;
    assign bus.retired      = r_retired;

endmodule
